// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory writer: packs big-endian bytes into words, one write per word.
// we pulses the cycle after a word's 4th byte; in_ready is high only while receiving, so the stream stalls during writes and when idle.
module imem_loader #(
    parameter int              DEPTH     = 8192,
    parameter int              BITS      = 32,
    parameter int              WIDTH     = 32,
    parameter logic [BITS-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BITS-1:0]  num_words,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             we,
    output logic [BITS-1:0]  waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [BITS-1:0]  words_written
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [BITS-1:0] DEPTH_W = BITS'(DEPTH);

    state_t           state, state_nxt;
    logic [1:0]       byte_cnt;
    logic [WIDTH-9:0] sr;
    logic [BITS-1:0]  num_words_q;
    logic [BITS-1:0]  words_inc;
    logic             start_acc;
    logic             byte_acc;
    logic             last_byte;
    logic             size_zero;
    logic             size_over;

    assign start_acc = start && (state == IDLE || state == DONE);
    assign byte_acc  = in_valid && in_ready;
    assign last_byte = byte_acc && (byte_cnt == 2'd3);
    assign size_zero = (num_words == '0);
    assign size_over = (num_words > DEPTH_W);
    assign words_inc = words_written + BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_acc) begin
                    state_nxt = (size_zero || size_over) ? DONE : RECV;
                end
            end
            RECV: begin
                if (last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = (words_inc == num_words_q) ? DONE : RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        we       = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        case (state)
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            WRITE: begin
                we       = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // waddr/wdata are captured with the 4th byte so they are stable throughout WRITE and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt      <= '0;
            sr            <= '0;
            num_words_q   <= '0;
            words_written <= '0;
            waddr         <= '0;
            wdata         <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            if (start_acc) begin
                num_words_q   <= num_words;
                words_written <= '0;
                byte_cnt      <= '0;
                sr            <= '0;
                done          <= size_zero || size_over;
                error         <= size_over;
            end
            if (byte_acc) begin
                sr       <= {sr[WIDTH-17:0], in_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    waddr <= BASE_ADDR + {words_written[BITS-3:0], 2'b00};
                    wdata <= {sr, in_data};
                end
            end
            if (state == WRITE) begin
                words_written <= words_inc;
                byte_cnt      <= '0;
                done          <= (words_inc == num_words_q);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads, write scoreboard, and hand-written corner sequences.
module tb_imem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        int          nw;
        bit          stall;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] words_written;

    logic        start_b;
    logic [31:0] num_words_b;
    logic        in_valid_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b;
    logic        we_b;
    logic [31:0] waddr_b;
    logic [31:0] wdata_b;
    logic        busy_b;
    logic        cpu_hold_b;
    logic        done_b;
    logic        error_b;
    logic [31:0] words_written_b;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          nwrites = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] mem [8192];
    wr_t         sbq[$];
    wr_t         mon_e;
    vec_t        tbl[6];

    imem_loader #(.DEPTH(8192), .BITS(32), .WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_written(words_written)
    );

    imem_loader #(.DEPTH(8192), .BITS(32), .WIDTH(32), .BASE_ADDR(32'h100)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .num_words(num_words_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .busy(busy_b), .cpu_hold(cpu_hold_b),
        .done(done_b), .error(error_b), .words_written(words_written_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard side: every write must match the oldest pending word and arrive the cycle after its 4th byte.
    always @(negedge clk) begin
        if (we) begin
            nwrites++;
            chk("in_ready_in_write", {31'b0, in_ready}, 32'h0);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we actual_addr=%h required=no_write", waddr);
            end else begin
                mon_e = sbq.pop_front();
                chk("waddr", waddr, mon_e.addr);
                chk("wdata", wdata, mon_e.data);
                chk("we_latency_cycle", cyc, mon_e.cyc);
            end
            mem[waddr[14:2]] = wdata;
            last_waddr = waddr;
        end
    end

    function automatic logic [31:0] word_of(input int i, input logic [31:0] w0, input logic [31:0] w1);
        if (i == 0) return w0;
        if (i == 1) return w1;
        return w0 + i * 32'h9E3779B9;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t = 0;
        if (stall) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input bit stall);
        wr_t e;
        for (int b = 0; b < 4; b++) begin
            send_byte(w[31 - 8*b -: 8], stall);
        end
        e.addr = 32'(idx) * 4;
        e.data = w;
        e.cyc  = cyc;
        sbq.push_back(e);
    endtask

    task automatic start_load(input int nw, input bit err);
        @(negedge clk);
        start     = 1'b1;
        num_words = 32'(nw);
        @(negedge clk);
        start = 1'b0;
        if (nw == 0 || err) begin
            chk("imm_done", {31'b0, done}, 32'h1);
            chk("imm_error", {31'b0, error}, {31'b0, err});
            chk("imm_busy", {31'b0, busy}, 32'h0);
        end else begin
            chk("acc_busy", {31'b0, busy}, 32'h1);
            chk("acc_cpu_hold", {31'b0, cpu_hold}, 32'h1);
            chk("acc_done", {31'b0, done}, 32'h0);
            chk("acc_error", {31'b0, error}, 32'h0);
            chk("acc_words_written", words_written, 32'h0);
        end
    endtask

    task automatic finish_load(input int nw_exp, input bit err, input int wr0);
        int t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("end_done", {31'b0, done}, 32'h1);
        chk("end_error", {31'b0, error}, {31'b0, err});
        chk("end_words_written", words_written, 32'(nw_exp));
        chk("end_busy", {31'b0, busy}, 32'h0);
        chk("end_cpu_hold", {31'b0, cpu_hold}, 32'h0);
        chk("end_in_ready", {31'b0, in_ready}, 32'h0);
        chk("write_count", 32'(nwrites - wr0), 32'(nw_exp));
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        if (nw_exp > 0) chk("last_waddr", last_waddr, 32'(nw_exp - 1) * 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        rst_n = 1'b0;
        start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
        start_b = 1'b0; num_words_b = '0; in_valid_b = 1'b0; in_data_b = '0;

        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_we", {31'b0, we}, 32'h0);
        chk("rst_waddr", waddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_busy_hold_done_err", {28'b0, busy, cpu_hold, done, error}, 32'h0);
        chk("rst_words_written", words_written, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{nw: 2,    stall: 1'b0, w0: 32'h8C010004, w1: 32'hAC020008, err: 1'b0};
        tbl[1] = '{nw: 0,    stall: 1'b0, w0: 32'h0,        w1: 32'h0,        err: 1'b0};
        tbl[2] = '{nw: 8193, stall: 1'b0, w0: 32'h0,        w1: 32'h0,        err: 1'b1};
        tbl[3] = '{nw: 2,    stall: 1'b1, w0: 32'h8C010004, w1: 32'hAC020008, err: 1'b0};
        tbl[4] = '{nw: 8192, stall: 1'b0, w0: 32'h01234567, w1: 32'hFEDCBA98, err: 1'b0};
        tbl[5] = '{nw: 1,    stall: 1'b1, w0: 32'hDEADBEEF, w1: 32'h0,        err: 1'b0};

        for (int i = 0; i < 6; i++) begin
            wr0 = nwrites;
            start_load(tbl[i].nw, tbl[i].err);
            if (!tbl[i].err) begin
                for (int w = 0; w < tbl[i].nw; w++) begin
                    send_word(w, word_of(w, tbl[i].w0, tbl[i].w1), tbl[i].stall);
                end
            end
            finish_load(tbl[i].err ? 0 : tbl[i].nw, tbl[i].err, wr0);
            if (tbl[i].nw == 2) chk("rom_read_addr4", mem[1], 32'hAC020008);
        end

        // Reset during the second byte of a word, then a fresh one-word load.
        start_load(2, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready_we", {30'b0, in_ready, we}, 32'h0);
        chk("midrst_waddr", waddr, 32'h0);
        chk("midrst_wdata", wdata, 32'h0);
        chk("midrst_busy_hold_done_err", {28'b0, busy, cpu_hold, done, error}, 32'h0);
        chk("midrst_words_written", words_written, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr0 = nwrites;
        start_load(1, 1'b0);
        send_word(0, 32'h0000000D, 1'b0);
        finish_load(1, 1'b0, wr0);
        chk("midrst_rom_word0", mem[0], 32'h0000000D);

        // A start while busy must not disturb a 3-word load.
        wr0 = nwrites;
        start_load(3, 1'b0);
        send_word(0, 32'h11111111, 1'b0);
        @(negedge clk);
        start = 1'b1;
        num_words = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", {31'b0, busy}, 32'h1);
        chk("ignored_start_words", words_written, 32'h1);
        send_word(1, 32'h22222222, 1'b0);
        send_word(2, 32'h33333333, 1'b0);
        finish_load(3, 1'b0, wr0);

        // Non-zero base address on the second instance.
        @(negedge clk);
        start_b = 1'b1;
        num_words_b = 32'd1;
        @(negedge clk);
        start_b = 1'b0;
        in_valid_b = 1'b1;
        in_data_b = 8'h12;
        @(negedge clk);
        chk("base_no_early_we1", {31'b0, we_b}, 32'h0);
        in_data_b = 8'h34;
        @(negedge clk);
        in_data_b = 8'h56;
        @(negedge clk);
        chk("base_no_early_we3", {31'b0, we_b}, 32'h0);
        in_data_b = 8'h78;
        @(negedge clk);
        in_valid_b = 1'b0;
        chk("base_we", {31'b0, we_b}, 32'h1);
        chk("base_waddr", waddr_b, 32'h100);
        chk("base_wdata", wdata_b, 32'h12345678);
        chk("base_in_ready", {31'b0, in_ready_b}, 32'h0);
        @(negedge clk);
        chk("base_done", {31'b0, done_b}, 32'h1);
        chk("base_words_written", words_written_b, 32'h1);
        chk("base_we_after", {31'b0, we_b}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequential writer for the instruction memory; the word-addressed instruction ROM is the reader side of the same storage.
- Accepts a program image as a byte stream over a valid/ready handshake and assembles big-endian (MIPS) 32-bit words.
- Issues one write per word into the instruction-memory write port at byte address BASE_ADDR + 4*index.
- Holds the processor in reset while loading and reports completion, word count and errors.

Parameters:
- DEPTH, 8192, number of words in instruction memory.
- BITS, 32, address width (byte address).
- WIDTH, 32, memory word width; fixed at 4 bytes per word.
- BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- num_words  input  BITS  number of words to load; sampled when start is accepted.
- in_valid  input  1  byte-stream data valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte this cycle.
- we  output  1  memory write enable, one-cycle pulse per word.
- waddr  output  BITS  byte address of the write.
- wdata  output  WIDTH  assembled word.
- busy  output  1  load in progress.
- cpu_hold  output  1  keeps the CPU in reset; equals busy.
- done  output  1  load finished; held until the next accepted start.
- error  output  1  num_words exceeded DEPTH; held until the next accepted start.
- words_written  output  BITS  count of words written in the current or last load.

Behaviour:
- Reset, asynchronous: state=IDLE, and every output (in_ready, we, waddr, wdata, busy, cpu_hold, done, error, words_written) is 0; the byte counter and shift register clear.
- FSM states are IDLE, RECV, WRITE, DONE.
- IDLE/DONE + start:
  - num_words==0 → DONE, done=1, no writes.
  - num_words>DEPTH → DONE, error=1, done=1, no writes.
  - otherwise → RECV, busy=1, words_written=0, done=0, error=0, byte_cnt=0.
- start is ignored in RECV/WRITE.
- RECV:
  - in_ready=1.
  - A byte transfers when in_valid&&in_ready.
  - The shift register takes {sr[23:0],in_data}, so the first byte lands in bits [31:24].
  - byte_cnt increments; when the 4th byte is accepted, go to WRITE.
  - in_valid low stalls with no timeout.
- WRITE, exactly one cycle:
  - in_ready=0, we=1, waddr=BASE_ADDR+4*words_written, wdata=assembled word.
  - On the next edge words_written increments and byte_cnt clears.
  - If the new count equals num_words → DONE, else → RECV.
- Write latency: we asserts in the cycle after the 4th byte handshake. Peak throughput is 1 word per 5 cycles.
- DONE: busy=0, cpu_hold=0, done=1, in_ready=0. Stray bytes are not accepted.
- we is 0 in every state except WRITE. waddr and wdata hold their last value when we=0.
- Address arithmetic is modulo 2^BITS. The DEPTH check guarantees no wrap within the memory.
- Reset asserted mid-load: immediate return to IDLE with we=0. A partially assembled word is discarded. Words already written remain in memory.

Test Plan:
- Load of 2 words: num_words=2, bytes 8C,01,00,04,AC,02,00,08 with in_valid held high → we pulses twice:
  - first at waddr=0x0, wdata=0x8C010004;
  - second at waddr=0x4, wdata=0xAC020008;
  - then done=1, words_written=2, busy/cpu_hold fall, and the ROM read at addr 4 returns 0xAC020008.
- Stalled stream: same load with in_valid toggled every other cycle → identical writes and data; no we before the 4th byte of each word; in_ready is 0 during WRITE.
- Boundaries:
  - num_words=0 → done=1 on the next edge, no we, error=0.
  - num_words=8193 → done=1, error=1, no we.
  - num_words=8192 → accepted, with the last waddr=0x7FFC.
- Reset mid-operation: assert rst_n=0 after 2 bytes of word 1 → all outputs 0, state IDLE. A new start with num_words=1 and bytes 00,00,00,0D writes 0x0000000D at 0x0.
- start ignored while busy: a start pulse with num_words=5 during a 3-word load → exactly 3 writes, words_written=3. A new start after done clears done/error and restarts at index 0.
- BASE_ADDR=0x100, 1 word 12,34,56,78 → we at waddr=0x100 with wdata=0x12345678.
